// File: rtl/lane_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lane_demux_pkg
// Description : Shared constants and helpers for the lane demultiplexer.
//               MODE encodings and the ceiling-log2 helper used to size the
//               channel select and the per-channel age counters.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package lane_demux_pkg;

  // MODE input encodings
  localparam logic MODE_HOLD = 1'b0;  // unselected channels keep their value
  localparam logic MODE_EXCL = 1'b1;  // unselected channels clear

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

  // Bit width needed to index/count up to 'value' items, never below 1.
  function automatic int unsigned width_of(input int unsigned value);
    int unsigned w;
    w = clog2(value);
    return (w == 0) ? 1 : w;
  endfunction

endpackage : lane_demux_pkg
`default_nettype wire

// File: rtl/lane_slot.sv
`default_nettype none
// ============================================================================
// Module      : lane_slot
// Description : One output channel of lane_demux: data register, age counter,
//               STALE flag and OUT_VALID strobe flop. Priority inside the slot
//               is clear > update > (wipe, expiry).
// Ports       : clk_i    - clock, rising edge
//               rst_ni   - asynchronous active-low reset
//               clr_i    - synchronous clear of all slot state
//               upd_i    - load data_i into this slot this cycle
//               wipe_i   - exclusive-mode clear (another slot was updated)
//               data_i   - value to load on update
//               data_o   - current channel value
//               valid_o  - one-cycle strobe following an update
//               stale_o  - channel timed out and was cleared
// Revision    : 1.0 - initial release
// ============================================================================
module lane_slot #(
  parameter int unsigned DW       = 1,
  parameter int unsigned AW       = 1,
  parameter int unsigned HOLD_CYC = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          upd_i,
  input  logic          wipe_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic          stale_o
);

  localparam logic [AW-1:0] c_hold      = AW'(HOLD_CYC);
  localparam bit            c_expire_en = (HOLD_CYC > 0);

  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] age_q, age_d;
  logic          stale_q, stale_d;
  logic          valid_q, valid_d;
  logic          w_expire;

  // Expiry fires only on the edge where the age first reaches HOLD_CYC;
  // once saturated the age no longer moves, so it cannot re-fire.
  assign w_expire = c_expire_en && (age_q != c_hold) &&
                    ((age_q + AW'(1)) == c_hold);

  always_comb begin
    data_d  = data_q;
    age_d   = age_q;
    stale_d = stale_q;
    valid_d = 1'b0;
    if (clr_i) begin
      data_d  = '0;
      age_d   = '0;
      stale_d = 1'b0;
    end else if (upd_i) begin
      // An update beats a same-cycle expiry.
      data_d  = data_i;
      age_d   = '0;
      stale_d = 1'b0;
      valid_d = 1'b1;
    end else begin
      if (age_q != c_hold) begin
        age_d = age_q + AW'(1);
      end
      if (w_expire) begin
        data_d  = '0;
        stale_d = 1'b1;
      end
      // Exclusive-mode wipe leaves the channel non-stale even if it would
      // have expired on this edge.
      if (wipe_i) begin
        data_d  = '0;
        stale_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      age_q   <= '0;
      stale_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      age_q   <= age_d;
      stale_q <= stale_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign stale_o = stale_q;

endmodule : lane_slot
`default_nettype wire

// File: rtl/lane_demux.sv
`default_nettype none
// ============================================================================
// Module      : lane_demux
// Description : Routes one input word to one of NCH output channels selected
//               by sel_i. HOLD mode keeps the other channels, EXCL mode clears
//               them. Each channel ages and clears itself after HOLD_CYC idle
//               cycles (0 disables). Out-of-range selects raise sel_err_o.
// Ports       : clk_i       - clock, rising edge
//               rst_ni      - asynchronous active-low reset
//               in_valid_i  - in_data_i / sel_i valid this cycle
//               in_ready_o  - request can be accepted (NOT clr_i)
//               in_data_i   - value to route
//               sel_i       - target channel index
//               mode_i      - 0 = HOLD, 1 = EXCL (sampled on accept only)
//               clr_i       - synchronous clear of all channels
//               out_data_o  - channel k at [k*DW +: DW]
//               out_valid_o - per-channel one-cycle update strobe
//               stale_o     - per-channel timed-out flag
//               sel_err_o   - one-cycle strobe on out-of-range select
// Revision    : 1.0 - initial release
// ============================================================================
module lane_demux
  import lane_demux_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned DW       = 1,
  parameter int unsigned HOLD_CYC = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [DW-1:0]                    in_data_i,
  input  logic [width_of(NCH)-1:0]         sel_i,
  input  logic                             mode_i,
  input  logic                             clr_i,
  output logic [NCH*DW-1:0]                out_data_o,
  output logic [NCH-1:0]                   out_valid_o,
  output logic [NCH-1:0]                   stale_o,
  output logic                             sel_err_o
);

  localparam int unsigned SW = width_of(NCH);
  localparam int unsigned AW = width_of(HOLD_CYC + 1);

  // One extra bit so NCH itself is representable when NCH = 2**SW.
  localparam logic [SW:0] c_nch = (SW + 1)'(NCH);

  logic w_req;
  logic w_sel_ok;
  logic w_accept;
  logic w_excl;
  logic sel_err_q, sel_err_d;

  assign in_ready_o = ~clr_i;
  assign w_req      = in_valid_i & ~clr_i;
  assign w_sel_ok   = ({1'b0, sel_i} < c_nch);
  assign w_accept   = w_req & w_sel_ok;
  assign w_excl     = (mode_i == MODE_EXCL);

  // Clear has priority, and w_req already excludes it, so the strobe stays
  // low on a clear cycle.
  assign sel_err_d  = w_req & ~w_sel_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err_o = sel_err_q;

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    logic w_hit;
    logic w_upd;
    logic w_wipe;

    assign w_hit  = (sel_i == SW'(k));
    assign w_upd  = w_accept & w_hit;
    assign w_wipe = w_accept & w_excl & ~w_hit;

    lane_slot #(
      .DW       (DW),
      .AW       (AW),
      .HOLD_CYC (HOLD_CYC)
    ) u_slot (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (clr_i),
      .upd_i   (w_upd),
      .wipe_i  (w_wipe),
      .data_i  (in_data_i),
      .data_o  (out_data_o[k*DW +: DW]),
      .valid_o (out_valid_o[k]),
      .stale_o (stale_o[k])
    );
  end

endmodule : lane_demux
`default_nettype wire

// File: tb/tb_lane_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_lane_demux
// Description : Directed self-checking bench for lane_demux. DUT "a" uses
//               NCH=4, DW=8, HOLD_CYC=5; DUT "b" uses NCH=3, DW=8, HOLD_CYC=0
//               to reach the out-of-range select path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_demux;

  logic clk;
  logic rst_n;

  // DUT a
  logic        a_in_valid;
  logic        a_in_ready;
  logic [7:0]  a_in_data;
  logic [1:0]  a_sel;
  logic        a_mode;
  logic        a_clr;
  logic [31:0] a_out_data;
  logic [3:0]  a_out_valid;
  logic [3:0]  a_stale;
  logic        a_sel_err;

  // DUT b
  logic        b_in_valid;
  logic        b_in_ready;
  logic [7:0]  b_in_data;
  logic [1:0]  b_sel;
  logic        b_mode;
  logic        b_clr;
  logic [23:0] b_out_data;
  logic [2:0]  b_out_valid;
  logic [2:0]  b_stale;
  logic        b_sel_err;

  int n_tests;
  int n_fail;

  lane_demux #(.NCH(4), .DW(8), .HOLD_CYC(5)) u_dut_a (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (a_in_valid),
    .in_ready_o  (a_in_ready),
    .in_data_i   (a_in_data),
    .sel_i       (a_sel),
    .mode_i      (a_mode),
    .clr_i       (a_clr),
    .out_data_o  (a_out_data),
    .out_valid_o (a_out_valid),
    .stale_o     (a_stale),
    .sel_err_o   (a_sel_err)
  );

  lane_demux #(.NCH(3), .DW(8), .HOLD_CYC(0)) u_dut_b (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (b_in_valid),
    .in_ready_o  (b_in_ready),
    .in_data_i   (b_in_data),
    .sel_i       (b_sel),
    .mode_i      (b_mode),
    .clr_i       (b_clr),
    .out_data_o  (b_out_data),
    .out_valid_o (b_out_valid),
    .stale_o     (b_stale),
    .sel_err_o   (b_sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one word on DUT a, then drop valid.
  task automatic write_a(input logic [1:0] sel, input logic [7:0] data,
                         input logic mode);
    a_in_valid = 1'b1;
    a_sel      = sel;
    a_in_data  = data;
    a_mode     = mode;
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic write_b(input logic [1:0] sel, input logic [7:0] data);
    b_in_valid = 1'b1;
    b_sel      = sel;
    b_in_data  = data;
    b_mode     = 1'b0;
    step();
    b_in_valid = 1'b0;
  endtask

  task automatic clear_a();
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    a_in_valid = 1'b0; a_in_data = 8'h00; a_sel = 2'd0; a_mode = 1'b0; a_clr = 1'b0;
    b_in_valid = 1'b0; b_in_data = 8'h00; b_sel = 2'd0; b_mode = 1'b0; b_clr = 1'b0;
    step();
    step();
    n_tests++;
    if (a_out_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected %h", a_out_data, 32'h0);
    end
    n_tests++;
    if ({a_out_valid, a_stale, a_sel_err} !== 9'h0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected %b", {a_out_valid, a_stale, a_sel_err}, 9'h0);
    end
    n_tests++;
    if (a_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", a_in_ready);
    end
    n_tests++;
    if ({b_out_data, b_out_valid, b_stale, b_sel_err} !== 31'h0) begin
      n_fail++; $display("FAIL reset_b: got %h expected 0", {b_out_data, b_out_valid, b_stale, b_sel_err});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_hold_mode();
    clear_a();
    write_a(2'd0, 8'h10, 1'b0);
    write_a(2'd1, 8'h20, 1'b0);
    write_a(2'd3, 8'h30, 1'b0);
    n_tests++;
    if (a_out_valid !== 4'b1000) begin
      n_fail++; $display("FAIL hold_valid_ch3: got %b expected %b", a_out_valid, 4'b1000);
    end
    n_tests++;
    if (a_out_data !== 32'h30002010) begin
      n_fail++; $display("FAIL hold_data_pre: got %h expected %h", a_out_data, 32'h30002010);
    end
    write_a(2'd2, 8'hA5, 1'b0);
    n_tests++;
    if (a_out_data !== 32'h30A52010) begin
      n_fail++; $display("FAIL hold_data: got %h expected %h", a_out_data, 32'h30A52010);
    end
    n_tests++;
    if (a_out_valid !== 4'b0100) begin
      n_fail++; $display("FAIL hold_valid_ch2: got %b expected %b", a_out_valid, 4'b0100);
    end
    step();
    n_tests++;
    if ({a_out_valid, a_out_data} !== {4'b0000, 32'h30A52010}) begin
      n_fail++; $display("FAIL hold_idle: got %h expected %h", {a_out_valid, a_out_data}, {4'b0000, 32'h30A52010});
    end
  endtask

  task automatic test_excl_mode();
    clear_a();
    write_a(2'd0, 8'h11, 1'b1);
    write_a(2'd1, 8'h22, 1'b1);
    n_tests++;
    if (a_out_data !== 32'h00002200) begin
      n_fail++; $display("FAIL excl_data: got %h expected %h", a_out_data, 32'h00002200);
    end
    n_tests++;
    if (a_stale !== 4'b0000) begin
      n_fail++; $display("FAIL excl_stale: got %b expected %b", a_stale, 4'b0000);
    end
    // MODE toggled with no accept must not wipe anything.
    a_mode = 1'b1;
    step();
    n_tests++;
    if (a_out_data !== 32'h00002200) begin
      n_fail++; $display("FAIL excl_mode_noaccept: got %h expected %h", a_out_data, 32'h00002200);
    end
    write_a(2'd3, 8'h33, 1'b0);
    n_tests++;
    if (a_out_data !== 32'h33002200) begin
      n_fail++; $display("FAIL excl_then_hold: got %h expected %h", a_out_data, 32'h33002200);
    end
  endtask

  task automatic test_expiry();
    clear_a();
    write_a(2'd3, 8'h7F, 1'b0);
    for (int i = 0; i < 4; i++) step();
    // Four idle edges after the write: ch3 still live; others hit age 5.
    n_tests++;
    if ({a_out_data[31:24], a_stale} !== {8'h7F, 4'b0111}) begin
      n_fail++; $display("FAIL expiry_before: got %h expected %h", {a_out_data[31:24], a_stale}, {8'h7F, 4'b0111});
    end
    step();
    n_tests++;
    if ({a_out_data, a_stale} !== {32'h0, 4'b1111}) begin
      n_fail++; $display("FAIL expiry_fire: got %h expected %h", {a_out_data, a_stale}, {32'h0, 4'b1111});
    end
    write_a(2'd3, 8'h42, 1'b0);
    n_tests++;
    if ({a_out_data, a_stale} !== {32'h42000000, 4'b0111}) begin
      n_fail++; $display("FAIL expiry_rewrite: got %h expected %h", {a_out_data, a_stale}, {32'h42000000, 4'b0111});
    end
    // Update on the exact edge where ch0 would expire: the update wins.
    clear_a();
    for (int i = 0; i < 4; i++) step();
    write_a(2'd0, 8'hE1, 1'b0);
    n_tests++;
    if ({a_out_data, a_stale, a_out_valid} !== {32'h000000E1, 4'b1110, 4'b0001}) begin
      n_fail++; $display("FAIL expiry_collide: got %h expected %h", {a_out_data, a_stale, a_out_valid}, {32'h000000E1, 4'b1110, 4'b0001});
    end
  endtask

  task automatic test_back_to_back();
    clear_a();
    for (int i = 1; i <= 3; i++) begin
      a_in_valid = 1'b1; a_sel = 2'd2; a_in_data = 8'(i * 16 + 3); a_mode = 1'b0;
      step();
      n_tests++;
      if ({a_out_valid, a_out_data[23:16]} !== {4'b0100, 8'(i * 16 + 3)}) begin
        n_fail++; $display("FAIL b2b_%0d: got %h expected %h", i, {a_out_valid, a_out_data[23:16]}, {4'b0100, 8'(i * 16 + 3)});
      end
    end
    a_in_valid = 1'b0;
    step();
    n_tests++;
    if (a_out_valid !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_end: got %b expected %b", a_out_valid, 4'b0000);
    end
  endtask

  task automatic test_clr();
    clear_a();
    write_a(2'd0, 8'hAA, 1'b0);
    write_a(2'd2, 8'hBB, 1'b0);
    a_clr = 1'b1; a_in_valid = 1'b1; a_sel = 2'd1; a_in_data = 8'h55; a_mode = 1'b0;
    #1;
    n_tests++;
    if (a_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL clr_ready: got %b expected 0", a_in_ready);
    end
    step();
    n_tests++;
    if ({a_out_data, a_out_valid, a_stale, a_sel_err} !== 41'h0) begin
      n_fail++; $display("FAIL clr_outputs: got %h expected 0", {a_out_data, a_out_valid, a_stale, a_sel_err});
    end
    a_clr = 1'b0; a_in_valid = 1'b0;
    #1;
    n_tests++;
    if (a_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL clr_ready_release: got %b expected 1", a_in_ready);
    end
  endtask

  task automatic test_sel_err();
    write_b(2'd0, 8'h0A);
    write_b(2'd1, 8'h0B);
    write_b(2'd3, 8'hFF);
    n_tests++;
    if (b_sel_err !== 1'b1) begin
      n_fail++; $display("FAIL selerr_pulse: got %b expected 1", b_sel_err);
    end
    n_tests++;
    if ({b_out_data, b_out_valid, b_stale} !== {24'h000B0A, 3'b000, 3'b000}) begin
      n_fail++; $display("FAIL selerr_nochange: got %h expected %h", {b_out_data, b_out_valid, b_stale}, {24'h000B0A, 3'b000, 3'b000});
    end
    step();
    n_tests++;
    if (b_sel_err !== 1'b0) begin
      n_fail++; $display("FAIL selerr_oneshot: got %b expected 0", b_sel_err);
    end
    write_b(2'd2, 8'hCC);
    n_tests++;
    if ({b_out_data, b_out_valid, b_sel_err} !== {24'hCC0B0A, 3'b100, 1'b0}) begin
      n_fail++; $display("FAIL selerr_valid_ch2: got %h expected %h", {b_out_data, b_out_valid, b_sel_err}, {24'hCC0B0A, 3'b100, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    clear_a();
    write_a(2'd0, 8'h5A, 1'b0);
    write_a(2'd3, 8'hC3, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({a_out_data, a_out_valid, a_stale, a_sel_err} !== 41'h0) begin
      n_fail++; $display("FAIL async_reset_a: got %h expected 0", {a_out_data, a_out_valid, a_stale, a_sel_err});
    end
    n_tests++;
    if (b_out_data !== 24'h0) begin
      n_fail++; $display("FAIL async_reset_b: got %h expected 0", b_out_data);
    end
    step();
    rst_n = 1'b1;
    write_a(2'd1, 8'h99, 1'b0);
    n_tests++;
    if ({a_out_data, a_out_valid} !== {32'h00009900, 4'b0010}) begin
      n_fail++; $display("FAIL async_first_accept: got %h expected %h", {a_out_data, a_out_valid}, {32'h00009900, 4'b0010});
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_hold_mode();
    test_excl_mode();
    test_expiry();
    test_back_to_back();
    test_clr();
    test_sel_err();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_lane_demux
`default_nettype wire
